// File: rtl/ntt16_pkg.sv
// Shared constants, FSM encoding and helpers for the 16-point NTT scheduler.
package ntt16_pkg;
  localparam int N            = 16;
  localparam int LOG_N        = 4;
  localparam int BF_PER_STAGE = 8;
  localparam int MODULUS      = 17;
  localparam int N_INV        = 16;  // 16 * 16 = 256 = 1 mod 17

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    SCALE,
    SDRAIN,
    FIN
  } state_t;

  // Low-bit mask of width s, i.e. half-1 for the butterfly span of stage s.
  function automatic logic [3:0] low_mask(input logic [1:0] s);
    return (4'd1 << s) - 4'd1;
  endfunction
endpackage

// File: rtl/ntt16_addr_gen.sv
// Combinational butterfly address and twiddle generator: (stage, k) -> u, v, tw.
module ntt16_addr_gen
  import ntt16_pkg::*;
(
  input  logic [1:0] stage,
  input  logic [2:0] k,
  output logic [3:0] u,
  output logic [3:0] v,
  output logic [2:0] tw
);
  logic [3:0] k4, mask;
  logic [2:0] grp_sh;

  assign k4     = {1'b0, k};
  assign mask   = low_mask(stage);
  assign grp_sh = {1'b0, stage} + 3'd1;

  // Group base (k>>s)*2*half plus offset inside the group; v sits half above u.
  assign u  = ((k4 >> stage) << grp_sh) + (k4 & mask);
  assign v  = u + (4'd1 << stage);
  assign tw = (k & mask[2:0]) << (2'd3 - stage);
endmodule

// File: rtl/ntt16_scheduler.sv
// Address/control scheduler for an in-place radix-2 16-point NTT.
// Define NTT16_INVERSE_EN to enable the inverse transform path (mode, scaling pass).
module ntt16_scheduler
  import ntt16_pkg::*;
#(
  parameter int PIPE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [3:0] rd_addr_u,
  output logic [3:0] rd_addr_v,
  output logic [3:0] tw_idx,
  output logic       scale_op,
  output logic       wr_en,
  output logic [3:0] wr_addr_u,
  output logic [3:0] wr_addr_v,
  output logic [1:0] stage
);
`ifdef NTT16_INVERSE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [3:0] BF_LAST    = 4'(BF_PER_STAGE - 1);
  localparam logic [3:0] SCALE_LAST = 4'(N - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(PIPE_LAT - 1);
  localparam logic [1:0] STAGE_LAST = 2'(LOG_N - 1);

  state_t     state;
  logic [1:0] stage_q;
  logic [3:0] cnt;
  logic       mode_q;
  logic       scale_q;
  logic [3:0] bf_u, bf_v;
  logic [2:0] bf_tw;

  ntt16_addr_gen u_addr_gen (
    .stage (stage_q),
    .k     (cnt[2:0]),
    .u     (bf_u),
    .v     (bf_v),
    .tw    (bf_tw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      stage_q <= '0;
      cnt     <= '0;
      mode_q  <= 1'b0;
      scale_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          stage_q <= '0;
          cnt     <= '0;
          mode_q  <= INV_EN && mode;
          busy    <= 1'b1;
          rd_en   <= 1'b1;
        end
        RUN: if (cnt == BF_LAST) begin
          state <= DRAIN;
          cnt   <= '0;
          rd_en <= 1'b0;
        end else begin
          cnt <= cnt + 4'd1;
        end
        // Hold reads off until the last write of this stage has issued.
        DRAIN: if (cnt == DRAIN_LAST) begin
          cnt <= '0;
          if (stage_q != STAGE_LAST) begin
            state   <= RUN;
            stage_q <= stage_q + 2'd1;
            rd_en   <= 1'b1;
          end else if (mode_q) begin
            state   <= SCALE;
            rd_en   <= 1'b1;
            scale_q <= 1'b1;
          end else begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end else begin
          cnt <= cnt + 4'd1;
        end
        SCALE: if (cnt == SCALE_LAST) begin
          state   <= SDRAIN;
          cnt     <= '0;
          rd_en   <= 1'b0;
          scale_q <= 1'b0;
        end else begin
          cnt <= cnt + 4'd1;
        end
        SDRAIN: if (cnt == DRAIN_LAST) begin
          state <= FIN;
          cnt   <= '0;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          cnt <= cnt + 4'd1;
        end
        FIN: begin
          state   <= IDLE;
          stage_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_addr_u = '0;
    rd_addr_v = '0;
    tw_idx    = '0;
    if (rd_en) begin
      if (scale_q) begin
        rd_addr_u = cnt;
        rd_addr_v = cnt;
      end else begin
        rd_addr_u = bf_u;
        rd_addr_v = bf_v;
        tw_idx    = {mode_q, bf_tw};
      end
    end
  end

  assign scale_op = INV_EN && scale_q;
  assign stage    = stage_q;

  // Write delay line free-runs so in-flight writes drain regardless of FSM state.
  logic [PIPE_LAT:1]      vld_pipe;
  logic [PIPE_LAT:1][3:0] wu_pipe, wv_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      wu_pipe  <= '0;
      wv_pipe  <= '0;
    end else begin
      vld_pipe[1] <= rd_en;
      wu_pipe[1]  <= rd_addr_u;
      wv_pipe[1]  <= rd_addr_v;
      for (int i = 2; i <= PIPE_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        wu_pipe[i]  <= wu_pipe[i-1];
        wv_pipe[i]  <= wv_pipe[i-1];
      end
    end
  end

  assign wr_en     = vld_pipe[PIPE_LAT];
  assign wr_addr_u = wu_pipe[PIPE_LAT];
  assign wr_addr_v = wv_pipe[PIPE_LAT];
endmodule

// File: doc/ntt16_scheduler.md
NTT16_SCHEDULER -- requirements
Module: ntt16_scheduler

Interface
REQ-001 Parameter PIPE_LAT, default 1: cycles from rd_en to matching wr_en (memory read latency plus butterfly registering); legal 1..4.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  one-cycle pulse; accepted only in IDLE, ignored otherwise.
REQ-005 Port mode  input  1  0 = forward NTT, 1 = inverse; sampled with accepted start.
REQ-006 Port busy  output  1  high from the cycle after accepted start until the cycle done pulses.
REQ-007 Port done  output  1  one-cycle pulse when all writes of the transform have issued.
REQ-008 Port rd_en  output  1  read strobe for coefficient memory.
REQ-009 Port rd_addr_u, rd_addr_v  output  4 each  read addresses of butterfly operands u, v.
REQ-010 Port tw_idx  output  4  twiddle ROM index, valid with rd_en; bit 3 selects inverse table.
REQ-011 Port scale_op  output  1  high with rd_en during the scaling pass (datapath multiplies u by N^-1, ignores v).
REQ-012 Port wr_en  output  1  write strobe; rd_en delayed by PIPE_LAT.
REQ-013 Port wr_addr_u, wr_addr_v  output  4 each  rd_addr_u/v delayed by PIPE_LAT.
REQ-014 Port stage  output  2  current stage number 0..3, for debug.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN, SCALE, SDRAIN, FIN.
REQ-016 IDLE -> RUN on start; stage=0, k=0.
REQ-017 RUN SHALL issue one butterfly per cycle, k = 0..7, rd_en=1 each cycle.
REQ-018 Address rule, stage s: half=1<<s; u = ((k>>s)<<(s+1)) + (k & (half-1)); v = u+half; tw_idx[2:0] = (k & (half-1)) << (3-s); tw_idx[3] = mode.
REQ-019 After k=7, RUN -> DRAIN; DRAIN holds rd_en=0 for exactly PIPE_LAT cycles, so no stage s+1 read precedes last stage-s write.
REQ-020 DRAIN exit: stage<3 -> RUN with stage+1, k=0; stage==3 and mode=0 -> FIN; stage==3 and mode=1 -> SCALE.
REQ-021 SCALE issues 16 cycles, rd_addr_u = 0..15, rd_addr_v = rd_addr_u, scale_op=1, tw_idx=0; then SDRAIN for PIPE_LAT cycles; then FIN.
REQ-022 FIN pulses done for one cycle, returns to IDLE; busy deasserts in the same cycle.
REQ-023 Forward total latency: start accepted at cycle 0 -> done at cycle 4*(8+PIPE_LAT)+1; inverse adds 16+PIPE_LAT.
REQ-024 wr_* SHALL be a PIPE_LAT-deep shift of rd_* and scale_op; the write pipeline SHALL always run, so writes drain even if FSM advances.
REQ-025 Input data is held in bit-reversed order by the loader; scheduler performs no reordering.
REQ-026 start during busy SHALL be ignored with no effect on state or outputs.

Reset
REQ-027 rst SHALL force IDLE, stage=0, k=0, clear write pipeline; busy, done, rd_en, wr_en, scale_op = 0; addresses and tw_idx = 0.
REQ-028 rst mid-transform SHALL abort with no further wr_en pulses; next cycle start accepted normally.

Configuration
REQ-029 Macro NTT16_INVERSE_EN: defined -> REQ-005, REQ-010 bit 3, REQ-020/021 inverse path active.
REQ-030 Undefined -> mode ignored, tw_idx[3]=0, scale_op tied 0, SCALE/SDRAIN unreachable and removable.

Structure
REQ-031 Shared package holds N=16, LOG_N=4, BF_PER_STAGE=8, FSM state encoding, and N^-1 mod MODULUS constant.
REQ-032 One sub-module, ntt16_addr_gen (combinational, stage & k -> u, v, tw_idx); write-delay line stays inline.

Verification
REQ-033 PIPE_LAT=1, mode=0, start at cycle 0 -> stage 0 reads (0,1),(2,3)..(14,15), tw_idx=0; done at cycle 37.
REQ-034 Stage 2, k=5 -> rd_addr_u=9, rd_addr_v=13, tw_idx=2; stage 3, k=7 -> u=7, v=15, tw_idx=7.
REQ-035 PIPE_LAT=3 -> each wr_addr equals rd_addr 3 cycles earlier; no read of stage s+1 before last write of stage s.
REQ-036 With NTT16_INVERSE_EN, mode=1 -> tw_idx[3]=1 throughout butterflies, 16 scale_op reads 0..15, done at cycle 4*(8+1)+16+1+1=54.
REQ-037 rst asserted at stage 1, k=3 -> next cycle all outputs 0, no wr_en afterwards; start 2 cycles later -> fresh run, done at expected latency.
REQ-038 start pulsed while busy -> no change in sequence or done timing; end-to-end with butterfly and MODULUS=17 matches software NTT of input 1,2..16.
